// File: rtl/eth_phy_loopback.sv
// eth_phy_loopback
// ----------------
// Link-side loopback between the TX PHY-facing beat stream (phy_*) and the
// RX MAC-facing beat stream (mac_*). Every accepted phy beat reappears on the
// mac side exactly one cycle later. The per-block terminate length is turned
// into a per-beat byte keep. Framing is checked, an inter-frame gap is
// enforced through phy_ready_o, and broken frames are cancelled.
//
// Optional feature: define LPBK_STATS_EN to add the frame_cnt_o / err_cnt_o
// statistics ports. They are absent from the default build.
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-high reset
//   phy_ctrl_v_i     in   beat is a control beat (start/idle/term)
//   phy_data_i       in   beat data, byte 0 in [7:0]
//   phy_start_i      in   start of frame
//   phy_idle_i       in   idle beat
//   phy_term_i       in   beat carries the final bytes of the frame
//   phy_term_len_i   in   valid bytes in the final BLOCK_N-byte block
//   phy_ready_o      out  a new beat is accepted this cycle
//   mac_valid_o      out  mac_* beat valid (1 every cycle after reset)
//   mac_cancel_o     out  one-cycle pulse: current frame aborted
//   mac_data_o       out  registered copy of phy_data_i
//   mac_ctrl_v_o     out  control beat
//   mac_idle_o       out  idle beat
//   mac_start_o      out  start of frame
//   mac_term_o       out  terminate beat
//   mac_term_keep_o  out  LSB-first thermometer of valid bytes on term beat
//   frame_cnt_o      out  (LPBK_STATS_EN) saturating count of good frames
//   err_cnt_o        out  (LPBK_STATS_EN) saturating count of ERR entries
module eth_phy_loopback #(
  parameter  int DATA_W      = 16,
  parameter  int BLOCK_N     = 8,
  parameter  int IFG_N       = 3,
  parameter  int MAX_BEATS   = 760,
  localparam int KEEP_W      = DATA_W / 8,
  localparam int BEAT_N      = BLOCK_N / KEEP_W,
  localparam int BLOCK_LEN_W = $clog2(BLOCK_N + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   phy_ctrl_v_i,
  input  logic [DATA_W-1:0]      phy_data_i,
  input  logic                   phy_start_i,
  input  logic                   phy_idle_i,
  input  logic                   phy_term_i,
  input  logic [BLOCK_LEN_W-1:0] phy_term_len_i,
  output logic                   phy_ready_o,
  output logic                   mac_valid_o,
  output logic                   mac_cancel_o,
  output logic [DATA_W-1:0]      mac_data_o,
  output logic                   mac_ctrl_v_o,
  output logic                   mac_idle_o,
  output logic                   mac_start_o,
  output logic                   mac_term_o,
`ifdef LPBK_STATS_EN
  output logic [15:0]            frame_cnt_o,
  output logic [15:0]            err_cnt_o,
`endif
  output logic [KEEP_W-1:0]      mac_term_keep_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int GAP_W = (IFG_N > 1) ? $clog2(IFG_N) : 1;
  localparam int NW    = BLOCK_LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR,
    ST_GAP
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_beatCnt;
  logic [GAP_W-1:0]         r_gapCnt;

  logic [CNT_W-1:0]         w_beatIdx;
  logic [BLOCK_LEN_W-1:0]   w_offset;
  logic signed [NW-1:0]     w_n;
  logic                     w_lenOk;
  logic [KEEP_W-1:0]        w_keep;
  logic                     w_isData;
  logic                     w_isStart;
  logic                     w_isIdle;
  logic                     w_frameErr;
  logic                     w_goodTerm;
  logic                     w_errEntry;

  // Beat classification and terminate-length decoding. The term length
  // describes the whole final block, so the bytes already sent in this
  // block (beat_idx*KEEP_W) are subtracted to get the bytes left for this
  // beat; anything outside 0..KEEP_W means the frame length is inconsistent.
  // w_goodTerm / w_errEntry are the single source of truth shared by the FSM
  // and the optional statistics counters.
  always_comb begin
    w_beatIdx  = r_beatCnt % CNT_W'(BEAT_N);
    w_offset   = BLOCK_LEN_W'(w_beatIdx * CNT_W'(KEEP_W));
    w_n        = $signed({1'b0, phy_term_len_i}) - $signed({1'b0, w_offset});
    w_lenOk    = !w_n[NW-1] && (w_n[NW-2:0] <= (NW-1)'(KEEP_W));
    w_keep     = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      w_keep[k] = (w_n[NW-2:0] > (NW-1)'(k));
    end
    w_isData   = !phy_ctrl_v_i;
    w_isStart  = phy_ctrl_v_i && phy_start_i;
    w_isIdle   = phy_ctrl_v_i && phy_idle_i;
    w_frameErr = w_isStart || w_isIdle || (phy_term_i && !w_lenOk) ||
                 (w_isData && (r_beatCnt == CNT_W'(MAX_BEATS)));
    w_goodTerm = phy_ready_o && (r_state == ST_DATA) && phy_term_i && !w_frameErr;
    w_errEntry = phy_ready_o &&
                 (((r_state == ST_IDLE) && (w_isData || (w_isStart && phy_term_i))) ||
                  ((r_state == ST_DATA) && w_frameErr));
  end

  // Main loopback FSM with registered mac_* outputs. Every cycle defaults to
  // an idle beat; only accepted start/data/term beats overwrite the data
  // register, so idle or gap cycles never disturb mac_data_o. A frame error
  // inside DATA produces the frame's one and only cancel pulse; errors seen
  // in IDLE happen before any start was forwarded and so need no cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_beatCnt       <= '0;
      r_gapCnt        <= '0;
      phy_ready_o     <= 1'b0;
      mac_valid_o     <= 1'b0;
      mac_cancel_o    <= 1'b0;
      mac_data_o      <= '0;
      mac_ctrl_v_o    <= 1'b0;
      mac_idle_o      <= 1'b1;
      mac_start_o     <= 1'b0;
      mac_term_o      <= 1'b0;
      mac_term_keep_o <= '0;
    end else begin
      mac_valid_o     <= 1'b1;
      mac_cancel_o    <= 1'b0;
      mac_ctrl_v_o    <= 1'b1;
      mac_idle_o      <= 1'b1;
      mac_start_o     <= 1'b0;
      mac_term_o      <= 1'b0;
      mac_term_keep_o <= '0;
      case (r_state)
        ST_IDLE: begin
          phy_ready_o <= 1'b1;
          if (w_errEntry) begin
            r_state <= ST_ERR;
          end else if (phy_ready_o && w_isStart) begin
            r_state     <= ST_DATA;
            r_beatCnt   <= '0;
            mac_start_o <= 1'b1;
            mac_idle_o  <= 1'b0;
            mac_data_o  <= phy_data_i;
          end
        end
        ST_DATA: begin
          if (w_errEntry) begin
            mac_cancel_o <= 1'b1;
            r_state      <= ST_ERR;
          end else if (w_goodTerm) begin
            mac_term_o      <= 1'b1;
            mac_idle_o      <= 1'b0;
            mac_term_keep_o <= w_keep;
            mac_data_o      <= phy_data_i;
            phy_ready_o     <= 1'b0;
            r_gapCnt        <= GAP_W'(IFG_N - 1);
            r_state         <= ST_GAP;
          end else if (w_isData) begin
            mac_ctrl_v_o <= 1'b0;
            mac_idle_o   <= 1'b0;
            mac_data_o   <= phy_data_i;
            r_beatCnt    <= r_beatCnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          if (phy_ready_o && phy_idle_i) begin
            phy_ready_o <= 1'b0;
            r_gapCnt    <= GAP_W'(IFG_N - 1);
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gapCnt == '0) begin
            phy_ready_o <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_gapCnt <= r_gapCnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LPBK_STATS_EN
  // Saturating statistics: good terminations and every entry into ERR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (w_goodTerm && (frame_cnt_o != 16'hFFFF)) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (w_errEntry && (err_cnt_o != 16'hFFFF)) begin
        err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule
